// File: rtl/reconcat_unpack_if.sv
// rtl/reconcat_unpack_if.sv - pixel stream and config bundle for reconcat_unpack
interface reconcat_unpack_if #(
    parameter int C_MAX_PORT_NUM           = 4,
    parameter int C_MAX_BPC                = 8,
    parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 4
);
    logic [7:0]                                          SRC_DDR_BYTE_NUM_I;
    logic [3:0]                                          SRC_BPC_I;
    logic                                                PIXEL_VS_I;
    logic                                                PIXEL_HS_I;
    logic                                                PIXEL_DE_I;
    logic [C_DDR_PIXEL_MAX_BYTE_NUM*8*C_MAX_PORT_NUM-1:0] PIXEL_DATA_I;
    logic                                                PIXEL_VS_O;
    logic                                                PIXEL_HS_O;
    logic                                                PIXEL_DE_O;
    logic [C_MAX_BPC*3*C_MAX_PORT_NUM-1:0]               PIXEL_DATA_O;
    logic                                                CFG_ERR_O;

    modport master (
        output SRC_DDR_BYTE_NUM_I, SRC_BPC_I, PIXEL_VS_I, PIXEL_HS_I, PIXEL_DE_I, PIXEL_DATA_I,
        input  PIXEL_VS_O, PIXEL_HS_O, PIXEL_DE_O, PIXEL_DATA_O, CFG_ERR_O
    );

    modport slave (
        input  SRC_DDR_BYTE_NUM_I, SRC_BPC_I, PIXEL_VS_I, PIXEL_HS_I, PIXEL_DE_I, PIXEL_DATA_I,
        output PIXEL_VS_O, PIXEL_HS_O, PIXEL_DE_O, PIXEL_DATA_O, CFG_ERR_O
    );
endinterface

// File: rtl/reconcat_unpack.sv
// rtl/reconcat_unpack.sv - unpack tight DDR pixel slots into per-port expanded {R,G,B}
module reconcat_unpack #(
    parameter int C_MAX_PORT_NUM           = 4,
    parameter int C_MAX_BPC                = 8,
    parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 4
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    reconcat_unpack_if.slave pix
);
    localparam int OW = C_MAX_BPC * 3 * C_MAX_PORT_NUM;

    logic [7:0] n_sh;
    logic [4:0] b_sh;
    logic       vs_d;
    logic       vs_rise;
    logic [4:0] b_in;
    logic       legal;
    logic [15:0] mask;
    logic [63:0] top;
    logic [31:0] wide;
    logic [31:0] rep;

    logic [C_MAX_PORT_NUM-1:0][2:0][15:0] comp_c;
    logic [C_MAX_PORT_NUM-1:0][2:0][15:0] comp_s1;
    logic [4:0]                            b_s1;
    logic [2:0]                            sync_s1;
    logic [OW-1:0]                         data_c;

    function automatic logic is_legal(input logic [7:0] n, input logic [4:0] b);
        logic n_ok;
        logic b_ok;
        n_ok = (n == 8'd2 || n == 8'd3 || n == 8'd4 || n == 8'd8) &&
               (int'(n) <= C_DDR_PIXEL_MAX_BYTE_NUM);
        b_ok = (b == 5'd6 || b == 5'd8 || b == 5'd10 || b == 5'd12 || b == 5'd16) &&
               (int'(b) <= C_MAX_BPC);
        return n_ok && b_ok && (3 * int'(b) <= 8 * int'(n));
    endfunction

    assign vs_rise = pix.PIXEL_VS_I & ~vs_d;
    assign b_in    = (pix.SRC_BPC_I == 4'd0) ? 5'd16 : {1'b0, pix.SRC_BPC_I};
    assign legal   = is_legal(n_sh, b_sh);
    assign mask    = ~(16'hFFFF >> b_sh);

    // Stage 1: left-align each slot in a 64-bit window, then peel R/G/B off the top.
    // Components stay MSB-aligned in 16 bits so stage 2 can replicate by plain shifts.
    always_comb begin
        comp_c = '0;
        top    = '0;
        for (int p = 0; p < C_MAX_PORT_NUM; p++) begin
            top = 64'(pix.PIXEL_DATA_I >> (p * 8 * int'(n_sh))) << (64 - 8 * int'(n_sh));
            for (int c = 0; c < 3; c++) begin
                comp_c[p][c] = legal ? (16'((top << (c * int'(b_sh))) >> 48) & mask) : 16'd0;
            end
        end
    end

    // Stage 2: three staggered copies cover C_MAX_BPC since B >= 6 and C_MAX_BPC <= 16.
    always_comb begin
        data_c = '0;
        wide   = '0;
        rep    = '0;
        for (int p = 0; p < C_MAX_PORT_NUM; p++) begin
            for (int c = 0; c < 3; c++) begin
                wide = {comp_s1[p][c], 16'd0};
                rep  = wide | (wide >> b_s1) | (wide >> (6'(b_s1) << 1));
                data_c[p*3*C_MAX_BPC + (2-c)*C_MAX_BPC +: C_MAX_BPC] = C_MAX_BPC'(rep >> (32 - C_MAX_BPC));
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            n_sh             <= 8'(C_DDR_PIXEL_MAX_BYTE_NUM);
            b_sh             <= 5'(C_MAX_BPC);
            vs_d             <= 1'b0;
            comp_s1          <= '0;
            b_s1             <= 5'(C_MAX_BPC);
            sync_s1          <= 3'b000;
            pix.PIXEL_DATA_O <= '0;
            pix.PIXEL_VS_O   <= 1'b0;
            pix.PIXEL_HS_O   <= 1'b0;
            pix.PIXEL_DE_O   <= 1'b0;
            pix.CFG_ERR_O    <= 1'b0;
        end else begin
            vs_d <= pix.PIXEL_VS_I;
            if (vs_rise) begin
                n_sh <= pix.SRC_DDR_BYTE_NUM_I;
                b_sh <= b_in;
            end
            pix.CFG_ERR_O <= ~legal;
            comp_s1       <= comp_c;
            b_s1          <= b_sh;
            sync_s1       <= {pix.PIXEL_VS_I, pix.PIXEL_HS_I, pix.PIXEL_DE_I};
            pix.PIXEL_DATA_O <= data_c;
            {pix.PIXEL_VS_O, pix.PIXEL_HS_O, pix.PIXEL_DE_O} <= sync_s1;
        end
    end
endmodule

// File: tb/tb_reconcat_unpack.sv
// tb/tb_reconcat_unpack.sv - randomized self-checking bench for reconcat_unpack
module tb_reconcat_unpack;
    localparam int P   = 4;
    localparam int BPC = 8;
    localparam int NB  = 4;
    localparam int DW  = NB * 8 * P;
    localparam int OW  = BPC * 3 * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reconcat_unpack_if #(.C_MAX_PORT_NUM(P), .C_MAX_BPC(BPC), .C_DDR_PIXEL_MAX_BYTE_NUM(NB)) bus();

    reconcat_unpack #(.C_MAX_PORT_NUM(P), .C_MAX_BPC(BPC), .C_DDR_PIXEL_MAX_BYTE_NUM(NB)) dut (
        .CLK_I  (clk),
        .RSTN_I (rst_n),
        .pix    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int            m_n, m_b;
    logic          m_vs_prev;
    logic [OW-1:0] m_prev_data, m_out_data;
    logic [2:0]    m_prev_sync, m_out_sync;
    logic          m_err;

    function automatic int dec_b(input logic [3:0] code);
        return (code == 4'd0) ? 16 : int'(code);
    endfunction

    function automatic bit legal_m(input int n, input int b);
        bit n_ok, b_ok;
        n_ok = (n == 2 || n == 3 || n == 4 || n == 8) && n <= NB;
        b_ok = (b == 6 || b == 8 || b == 10 || b == 12 || b == 16) && b <= BPC;
        return n_ok && b_ok && (3 * b <= 8 * n);
    endfunction

    // Output bit j (MSB first) of component c on port p is bit (j mod B) of that component, MSB first.
    function automatic logic [OW-1:0] ref_pixels(input logic [DW-1:0] d, input int n, input int b);
        logic [OW-1:0] r;
        int src;
        r = '0;
        if (!legal_m(n, b)) return r;
        for (int p = 0; p < P; p++)
            for (int c = 0; c < 3; c++)
                for (int j = 0; j < BPC; j++) begin
                    src = p*8*n + 8*n - 1 - c*b - (j % b);
                    r[p*3*BPC + (2-c)*BPC + BPC-1-j] = d[src];
                end
        return r;
    endfunction

    task automatic model_reset();
        m_n = NB; m_b = BPC; m_vs_prev = 1'b0; m_err = 1'b0;
        m_prev_data = '0; m_out_data = '0; m_prev_sync = '0; m_out_sync = '0;
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input logic [DW-1:0] d);
        @(negedge clk);
        bus.PIXEL_VS_I = vs; bus.PIXEL_HS_I = hs; bus.PIXEL_DE_I = de; bus.PIXEL_DATA_I = d;
        @(posedge clk);
        #1;
        m_err       = !legal_m(m_n, m_b);
        m_out_data  = m_prev_data;
        m_out_sync  = m_prev_sync;
        m_prev_data = ref_pixels(d, m_n, m_b);
        m_prev_sync = {vs, hs, de};
        if (vs && !m_vs_prev) begin
            m_n = int'(bus.SRC_DDR_BYTE_NUM_I);
            m_b = dec_b(bus.SRC_BPC_I);
        end
        m_vs_prev = vs;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic test_reset();
        bus.SRC_DDR_BYTE_NUM_I = 8'd4; bus.SRC_BPC_I = 4'd8;
        bus.PIXEL_VS_I = 1'b0; bus.PIXEL_HS_I = 1'b0; bus.PIXEL_DE_I = 1'b0; bus.PIXEL_DATA_I = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O} !== 4'b0000 || bus.PIXEL_DATA_O !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got sync/err=%b data=%h want 0", {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O}, bus.PIXEL_DATA_O);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, rand_data());
            n_vec++;
            if (bus.PIXEL_DATA_O !== m_out_data || {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O} !== {m_out_sync, m_err}) begin
                n_bad++;
                $display("FAIL default_cfg: got %h/%b want %h/%b", bus.PIXEL_DATA_O, {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O}, m_out_data, {m_out_sync, m_err});
            end
        end
    endtask

    task automatic test_slot_formats();
        logic [DW-1:0] d;
        logic [23:0]   want [3];
        int            ncfg [3] = '{3, 4, 3};
        logic [3:0]    bcfg [3] = '{4'd8, 4'd8, 4'd6};
        want = '{24'h112233, 24'hAABBCC, 24'hFF8204};
        for (int t = 0; t < 3; t++) begin
            bus.SRC_DDR_BYTE_NUM_I = 8'(ncfg[t]); bus.SRC_BPC_I = bcfg[t];
            d = rand_data();
            if (t == 0) begin d[23:0] = 24'h112233; d[47:24] = 24'hAABBCC; end
            if (t == 1) d[31:0] = 32'hAABBCC5A;
            if (t == 2) d[23:0] = {6'h3F, 6'h20, 6'h01, 6'h00};
            step(1'b1, 1'b0, 1'b0, rand_data());
            step(1'b0, 1'b1, 1'b1, d);
            step(1'b0, 1'b0, 1'b0, rand_data());
            n_vec++;
            if (bus.PIXEL_DATA_O[23:0] !== want[t] || bus.PIXEL_DE_O !== 1'b1 || bus.CFG_ERR_O !== 1'b0) begin
                n_bad++;
                $display("FAIL slot_fmt%0d: got port0=%h de=%b err=%b want %h 1 0", t, bus.PIXEL_DATA_O[23:0], bus.PIXEL_DE_O, bus.CFG_ERR_O, want[t]);
            end
            if (t == 0) begin
                n_vec++;
                if (bus.PIXEL_DATA_O[47:24] !== 24'hAABBCC) begin
                    n_bad++;
                    $display("FAIL slot_fmt_port1: got %h want aabbcc", bus.PIXEL_DATA_O[47:24]);
                end
            end
            n_vec++;
            if (bus.PIXEL_DATA_O !== m_out_data) begin
                n_bad++;
                $display("FAIL slot_fmt%0d_model: got %h want %h", t, bus.PIXEL_DATA_O, m_out_data);
            end
        end
    endtask

    task automatic test_illegal();
        bus.SRC_DDR_BYTE_NUM_I = 8'd2; bus.SRC_BPC_I = 4'd10;
        step(1'b1, 1'b0, 1'b0, rand_data());
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i % 2), 1'b1, rand_data());
            n_vec++;
            if (bus.CFG_ERR_O !== 1'b1 || (i >= 1 && bus.PIXEL_DATA_O !== '0)) begin
                n_bad++;
                $display("FAIL illegal_cfg%0d: got err=%b data=%h want err=1 data=0", i, bus.CFG_ERR_O, bus.PIXEL_DATA_O);
            end
        end
        bus.SRC_DDR_BYTE_NUM_I = 8'd4; bus.SRC_BPC_I = 4'd8;
        step(1'b1, 1'b0, 1'b1, rand_data());
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, rand_data());
            n_vec++;
            if (bus.CFG_ERR_O !== 1'b0 || bus.PIXEL_DATA_O !== m_out_data) begin
                n_bad++;
                $display("FAIL illegal_recover%0d: got err=%b data=%h want err=0 data=%h", i, bus.CFG_ERR_O, bus.PIXEL_DATA_O, m_out_data);
            end
        end
    endtask

    task automatic test_midframe_change();
        bus.SRC_DDR_BYTE_NUM_I = 8'd3; bus.SRC_BPC_I = 4'd8;
        step(1'b1, 1'b0, 1'b0, rand_data());
        for (int i = 0; i < 16; i++) begin
            bus.SRC_BPC_I = 4'($urandom_range(0, 15));
            bus.SRC_DDR_BYTE_NUM_I = 8'($urandom_range(0, 9));
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_data());
            n_vec++;
            if (bus.PIXEL_DATA_O !== m_out_data || {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O} !== {m_out_sync, m_err}) begin
                n_bad++;
                $display("FAIL midframe%0d: got %h/%b want %h/%b", i, bus.PIXEL_DATA_O, {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O}, m_out_data, {m_out_sync, m_err});
            end
        end
    endtask

    task automatic test_random_frames();
        int         n_pool [5] = '{2, 3, 4, 8, 5};
        logic [3:0] b_pool [6] = '{4'd6, 4'd8, 4'd10, 4'd12, 4'd0, 4'd7};
        logic       vs;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                bus.SRC_DDR_BYTE_NUM_I = 8'(n_pool[$urandom_range(0, 4)]);
                bus.SRC_BPC_I = b_pool[$urandom_range(0, 5)];
            end
            vs = (i % 25 < 2);
            step(vs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_data());
            n_vec++;
            if (bus.PIXEL_DATA_O !== m_out_data || {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O} !== {m_out_sync, m_err}) begin
                n_bad++;
                $display("FAIL random%0d n=%0d b=%0d: got %h/%b want %h/%b", i, m_n, m_b, bus.PIXEL_DATA_O, {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O}, m_out_data, {m_out_sync, m_err});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        bus.SRC_DDR_BYTE_NUM_I = 8'd3; bus.SRC_BPC_I = 4'd8;
        step(1'b1, 1'b0, 1'b0, rand_data());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, rand_data());
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O} !== 4'b0000 || bus.PIXEL_DATA_O !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got sync/err=%b data=%h want 0", {bus.PIXEL_VS_O, bus.PIXEL_HS_O, bus.PIXEL_DE_O, bus.CFG_ERR_O}, bus.PIXEL_DATA_O);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        bus.SRC_DDR_BYTE_NUM_I = 8'd2; bus.SRC_BPC_I = 4'd6;
        d = rand_data();
        step(1'b0, 1'b0, 1'b1, d);
        step(1'b0, 1'b0, 1'b0, rand_data());
        n_vec++;
        if (bus.PIXEL_DATA_O[23:0] !== d[31:8] || bus.PIXEL_DE_O !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_beat: got port0=%h de=%b want %h 1", bus.PIXEL_DATA_O[23:0], bus.PIXEL_DE_O, d[31:8]);
        end
        n_vec++;
        if (bus.PIXEL_DATA_O !== m_out_data || bus.CFG_ERR_O !== m_err) begin
            n_bad++;
            $display("FAIL post_reset_model: got %h err=%b want %h err=%b", bus.PIXEL_DATA_O, bus.CFG_ERR_O, m_out_data, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_slot_formats();
        test_illegal();
        test_midframe_change();
        test_random_frames();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
